// File: rtl/dlatch_wr_arbiter.sv
// Round-robin write sequencer for a bank of four DW-bit D latches sharing one data bus.
// Each write runs SETUP/PULSE/HOLD so data is stable around a single-cycle, flop-driven enable.
module dlatch_wr_arbiter #(
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      req,
   input  logic [4*DW-1:0] wr_d,
   input  logic [7:0]      wr_addr,
   output logic [3:0]      gnt,
   output logic [3:0]      ack,
   output logic [DW-1:0]   lat_d,
   output logic [3:0]      lat_en,
   output logic            busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] PULSE = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [3:0]    ack_q, ack_d;
   logic [3:0]    lat_en_q, lat_en_d;
   logic [DW-1:0] lat_d_q, lat_d_d;
   logic          busy_q, busy_d;
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [1:0]    addr_q, addr_d;

   logic          win_vld;
   logic [1:0]    win_idx;
   logic [1:0]    idx;

   // Scan offsets high to low so the nearest requester at or above rr_ptr wins.
   always_comb begin
      win_vld = 1'b0;
      win_idx = 2'd0;
      idx     = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         idx = rr_ptr_q + 2'(k);
         if (req[idx]) begin
            win_vld = 1'b1;
            win_idx = idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      ack_d    = 4'b0000;
      lat_en_d = 4'b0000;
      lat_d_d  = lat_d_q;
      busy_d   = busy_q;
      rr_ptr_d = rr_ptr_q;
      addr_d   = addr_q;
      case (state_q)
         IDLE: begin
            gnt_d  = 4'b0000;
            busy_d = 1'b0;
            if (win_vld) begin
               state_d  = SETUP;
               gnt_d    = 4'b0001 << win_idx;
               lat_d_d  = wr_d[win_idx*DW +: DW];
               addr_d   = wr_addr[win_idx*2 +: 2];
               rr_ptr_d = win_idx + 2'd1;
               busy_d   = 1'b1;
            end
         end
         SETUP: begin
            state_d  = PULSE;
            lat_en_d = 4'b0001 << addr_q;
         end
         PULSE: begin
            state_d = HOLD;
            ack_d   = gnt_q;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Async reset also drops lat_en immediately, aborting any write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= 4'b0000;
         ack_q    <= 4'b0000;
         lat_en_q <= 4'b0000;
         lat_d_q  <= '0;
         busy_q   <= 1'b0;
         rr_ptr_q <= 2'd0;
         addr_q   <= 2'd0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         ack_q    <= ack_d;
         lat_en_q <= lat_en_d;
         lat_d_q  <= lat_d_d;
         busy_q   <= busy_d;
         rr_ptr_q <= rr_ptr_d;
         addr_q   <= addr_d;
      end
   end

   assign gnt    = gnt_q;
   assign ack    = ack_q;
   assign lat_en = lat_en_q;
   assign lat_d  = lat_d_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_dlatch_wr_arbiter.sv
// Directed bench for dlatch_wr_arbiter with a behavioural latch bank on lat_en/lat_d.
module tb_dlatch_wr_arbiter;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req;
   logic [4*DW-1:0] wr_d;
   logic [7:0]      wr_addr;
   logic [3:0]      gnt, ack, lat_en;
   logic [DW-1:0]   lat_d;
   logic            busy;
   logic [DW-1:0]   bank [4];

   int checks = 0;
   int errors = 0;

   dlatch_wr_arbiter #(.DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .wr_d(wr_d), .wr_addr(wr_addr),
      .gnt(gnt), .ack(ack), .lat_d(lat_d), .lat_en(lat_en), .busy(busy)
   );

   always #5 clk = ~clk;

   always_latch begin
      for (int i = 0; i < 4; i++)
         if (lat_en[i]) bank[i] = lat_d;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; wr_d = '0; wr_addr = 8'h00;
      for (int i = 0; i < 4; i++) bank[i] = 8'h00;
      #2;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_en", 32'(lat_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_latd", 32'(lat_d), 0);
      tick(); tick();
      chk("rst_hold_gnt", 32'(gnt), 0);
      #3 rst = 1'b0;

      // requesters 1 and 3 from rr_ptr=0: 1 first, then 3
      req = 4'b1010; wr_d = 32'h44_00_22_00; wr_addr = 8'b00_00_00_00;
      tick();
      chk("rr_g1", 32'(gnt), 32'b0010);
      chk("rr_latd1", 32'(lat_d), 32'h22);
      tick(); tick();
      chk("rr_ack1", 32'(ack), 32'b0010);
      req = 4'b1000;
      tick(); tick();
      chk("rr_g3", 32'(gnt), 32'b1000);
      chk("rr_latd3", 32'(lat_d), 32'h44);
      tick(); tick();
      chk("rr_ack3", 32'(ack), 32'b1000);
      req = 4'b0000;
      tick();
      chk("rr_idle", 32'(busy), 0);

      // single write: requester 0, 0xA5 into latch 2
      req = 4'b0001; wr_d = 32'h0000_00A5; wr_addr = 8'b00_00_00_10;
      tick();
      chk("sw_gnt_setup", 32'(gnt), 32'b0001);
      chk("sw_busy", 32'(busy), 1);
      chk("sw_latd", 32'(lat_d), 32'hA5);
      chk("sw_en_setup", 32'(lat_en), 0);
      req = 4'b0000;
      tick();
      chk("sw_en_pulse", 32'(lat_en), 32'b0100);
      chk("sw_gnt_pulse", 32'(gnt), 32'b0001);
      chk("sw_ack_pulse", 32'(ack), 0);
      tick();
      chk("sw_en_hold", 32'(lat_en), 0);
      chk("sw_ack_hold", 32'(ack), 32'b0001);
      chk("sw_gnt_hold", 32'(gnt), 32'b0001);
      tick();
      chk("sw_gnt_idle", 32'(gnt), 0);
      chk("sw_ack_idle", 32'(ack), 0);
      chk("sw_busy_idle", 32'(busy), 0);
      chk("sw_latd_idle", 32'(lat_d), 32'hA5);
      chk("sw_bank2", 32'(bank[2]), 32'hA5);

      // requester 2 drops req and changes data during PULSE (rr_ptr=1)
      req = 4'b0100; wr_d = 32'h003C_0000; wr_addr = 8'b00_01_00_00;
      tick();
      chk("chg_gnt", 32'(gnt), 32'b0100);
      tick();
      req = 4'b0000; wr_d = 32'h00FF_0000;
      chk("chg_en", 32'(lat_en), 32'b0010);
      chk("chg_latd", 32'(lat_d), 32'h3C);
      tick();
      chk("chg_ack", 32'(ack), 32'b0100);
      tick();
      chk("chg_bank1", 32'(bank[1]), 32'h3C);

      // requesters 0 and 1 both write latch 3 (rr_ptr=3 -> 0 wins first)
      req = 4'b0011; wr_d = 32'h0000_2211; wr_addr = 8'b00_00_11_11;
      tick();
      chk("same_g0", 32'(gnt), 32'b0001);
      tick(); tick();
      chk("same_ack0", 32'(ack), 32'b0001);
      req = 4'b0010;
      tick();
      chk("same_gap_ack", 32'(ack), 0);
      tick();
      chk("same_g1", 32'(gnt), 32'b0010);
      tick(); tick();
      chk("same_ack1", 32'(ack), 32'b0010);
      req = 4'b0000;
      tick();
      chk("same_bank3", 32'(bank[3]), 32'h22);

      // reset asserted mid-PULSE (rr_ptr=2, requester 1 wins)
      req = 4'b0010; wr_d = 32'h0000_7700; wr_addr = 8'b00_00_00_00;
      tick();
      chk("ab_gnt", 32'(gnt), 32'b0010);
      tick();
      chk("ab_en_pre", 32'(lat_en), 32'b0001);
      #3 rst = 1'b1;
      #1;
      chk("ab_en", 32'(lat_en), 0);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_gnt0", 32'(gnt), 0);
      tick();
      chk("ab_ack", 32'(ack), 0);
      #3 rst = 1'b0;

      // all four requesting continuously: grants 0,1,2,3,0 at 4-cycle spacing
      req = 4'b1111; wr_d = 32'hD3_C2_B1_A0; wr_addr = 8'b11_10_01_00;
      for (int g = 0; g < 5; g++) begin
         tick();
         chk("all_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
         chk("all_latd", 32'(lat_d), 32'(wr_d[(g % 4)*DW +: DW]));
         tick();
         chk("all_onehot", 32'($onehot0(gnt)), 1);
         tick();
         chk("all_ack", 32'(ack), 32'(4'b0001 << (g % 4)));
         tick();
         chk("all_gnt_idle", 32'(gnt), 0);
      end
      req = 4'b0000;
      tick(); tick(); tick(); tick();
      chk("end_busy", 32'(busy), 0);
      chk("end_bank3", 32'(bank[3]), 32'hD3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
